// File: rtl/tcp_payload_arb.sv
// Four-port payload byte arbiter: per-port FIFOs, round-robin grants held per packet,
// one backpressured output byte stream tagged with its source port.
module tcp_payload_arb #(
  parameter int FIFO_DEPTH   = 64,
  parameter int HOLD_TIMEOUT = 16
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [3:0]  in_valid,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_newpkt,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_sop,
  output logic [1:0]  out_port,
  input  logic        out_ready,
  output logic [3:0]  overflow,
  output logic [15:0] drop_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  logic [8:0]  fifoMem_r [4][FIFO_DEPTH];
  logic [AW:0] wrPtr_r [4];
  logic [AW:0] rdPtr_r [4];
  logic [3:0]  pendingSop_r;
  logic [3:0]  discard_r;

  state_t      state_r;
  logic [1:0]  grant_r;
  logic [1:0]  rrPtr_r;
  logic [7:0]  emptyCnt_r;
  logic        popped_r;

  logic [3:0]  empty_s;
  logic [3:0]  full_s;
  logic [3:0]  wrEn_s;
  logic [3:0]  fullDrop_s;
  logic [3:0]  drop_s;
  logic [2:0]  dropSum_s;
  logic [16:0] dropTotal_s;
  logic [15:0] dropNext_s;
  logic        anyReady_s;
  logic [1:0]  pick_s;
  logic [1:0]  scanIdx_s;
  logic        inGrant_s;
  logic        grantEmpty_s;
  logic [8:0]  headEntry_s;
  logic        exitSop_s;
  logic        exitTimeout_s;
  logic        pop_s;
  logic [3:0]  popOh_s;

  // Per-port FIFO status and write/drop decisions (full is judged before any same-cycle pop)
  always_comb begin
    empty_s    = 4'b0000;
    full_s     = 4'b0000;
    wrEn_s     = 4'b0000;
    fullDrop_s = 4'b0000;
    drop_s     = 4'b0000;
    dropSum_s  = 3'd0;
    for (int i = 0; i < 4; i++) begin
      empty_s[i]    = (wrPtr_r[i] == rdPtr_r[i]);
      full_s[i]     = (wrPtr_r[i][AW] != rdPtr_r[i][AW]) &&
                      (wrPtr_r[i][AW-1:0] == rdPtr_r[i][AW-1:0]);
      wrEn_s[i]     = in_valid[i] && !(discard_r[i] && !in_newpkt[i]) && !full_s[i];
      fullDrop_s[i] = in_valid[i] && !(discard_r[i] && !in_newpkt[i]) && full_s[i];
      drop_s[i]     = in_valid[i] && !wrEn_s[i];
      dropSum_s     = dropSum_s + {2'b00, drop_s[i]};
    end
    dropTotal_s = {1'b0, drop_count} + {14'd0, dropSum_s};
    dropNext_s  = dropTotal_s[16] ? 16'hFFFF : dropTotal_s[15:0];
  end

  // Round-robin scan from rrPtr+1 and grant-side pop/exit decisions
  always_comb begin
    anyReady_s = 1'b0;
    pick_s     = 2'd0;
    scanIdx_s  = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      scanIdx_s  = rrPtr_r + 2'(k);
      pick_s     = (!anyReady_s && !empty_s[scanIdx_s]) ? scanIdx_s : pick_s;
      anyReady_s = anyReady_s | !empty_s[scanIdx_s];
    end
    inGrant_s     = (state_r == GRANT);
    grantEmpty_s  = empty_s[grant_r];
    headEntry_s   = fifoMem_r[grant_r][rdPtr_r[grant_r][AW-1:0]];
    exitSop_s     = inGrant_s && !grantEmpty_s && headEntry_s[8] && popped_r;
    exitTimeout_s = inGrant_s && grantEmpty_s && (emptyCnt_r == HOLD_LAST);
    pop_s         = inGrant_s && !grantEmpty_s && !exitSop_s && (!out_valid || out_ready);
    popOh_s       = pop_s ? (4'b0001 << grant_r) : 4'b0000;
  end

  // FIFO storage; pointers alone define occupancy, so the array needs no reset
  always_ff @(posedge CLOCK) begin
    for (int i = 0; i < 4; i++) begin
      if (wrEn_s[i]) begin
        fifoMem_r[i][wrPtr_r[i][AW-1:0]] <= {pendingSop_r[i] | in_newpkt[i], in_data[8*i +: 8]};
      end
    end
  end

  // Pointers, start-of-packet tracking, discard mode and drop accounting
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      for (int i = 0; i < 4; i++) begin
        wrPtr_r[i] <= '0;
        rdPtr_r[i] <= '0;
      end
      pendingSop_r <= 4'b0000;
      discard_r    <= 4'b0000;
      overflow     <= 4'b0000;
      drop_count   <= 16'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wrEn_s[i]) wrPtr_r[i] <= wrPtr_r[i] + PTR_ONE;
        if (popOh_s[i]) rdPtr_r[i] <= rdPtr_r[i] + PTR_ONE;
        pendingSop_r[i] <= wrEn_s[i] ? 1'b0 : (pendingSop_r[i] | in_newpkt[i]);
        // newpkt leaves discard unless its own byte hit a full FIFO
        discard_r[i]    <= in_newpkt[i] ? fullDrop_s[i] : (discard_r[i] | fullDrop_s[i]);
        overflow[i]     <= overflow[i] | fullDrop_s[i];
      end
      drop_count <= dropNext_s;
    end
  end

  // Arbiter FSM and output register
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_r    <= IDLE;
      grant_r    <= 2'd0;
      rrPtr_r    <= 2'd3;
      emptyCnt_r <= 8'd0;
      popped_r   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= 8'd0;
      out_sop    <= 1'b0;
      out_port   <= 2'd0;
    end else begin
      if (pop_s) begin
        out_valid <= 1'b1;
        out_data  <= headEntry_s[7:0];
        out_sop   <= headEntry_s[8];
        out_port  <= grant_r;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (anyReady_s) begin
            state_r    <= GRANT;
            grant_r    <= pick_s;
            emptyCnt_r <= 8'd0;
            popped_r   <= 1'b0;
          end
        end
        GRANT: begin
          if (exitSop_s || exitTimeout_s) begin
            state_r <= IDLE;
            rrPtr_r <= grant_r;
          end
          emptyCnt_r <= grantEmpty_s ? (emptyCnt_r + 8'd1) : 8'd0;
          if (pop_s) popped_r <= 1'b1;
        end
        default: state_r <= IDLE;
      endcase
    end
  end
endmodule
